// File: rtl/seg_pkg.sv
// Shared constants, scan state type and anode helper for the 7-segment scan driver.
package seg_pkg;

    localparam int N_DIGITS = 4;
    localparam int IDX_W    = 2;

    // Segment patterns, gfedcba, active-low
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_ZERO  = 7'b1000000;
    localparam logic [6:0] SEG_ERR   = 7'b0011000;

    localparam logic [3:0] AN_OFF = 4'b1111;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } scan_state_t;

    // Active-low one-hot anode pattern for the selected digit
    function automatic logic [3:0] anode_sel(input logic [IDX_W-1:0] idx);
        logic [3:0] an;
        an      = AN_OFF;
        an[idx] = 1'b0;
        return an;
    endfunction

endpackage

// File: rtl/seg_scan_timer.sv
// Digit window timer: counts clocks inside each digit window, walks the digit index
// and reports where in the window / frame the scan currently is.
module seg_scan_timer
    import seg_pkg::*;
#(
    parameter int DIV_CNT   = 100000,
    parameter int BLANK_CYC = 16
) (
    input  logic             clk,
    input  logic             rst,
    output logic             show,
    output logic             blank_start,
    output logic             frame_end,
    output logic [IDX_W-1:0] idx
);

    localparam int CNT_W = (DIV_CNT > 1) ? $clog2(DIV_CNT) : 1;

    scan_state_t       state_r;
    scan_state_t       state_s;
    logic [CNT_W-1:0]  cnt_r;
    logic [CNT_W-1:0]  cnt_s;
    logic [IDX_W-1:0]  idx_r;
    logic [IDX_W-1:0]  idx_s;
    logic              win_end_s;

    assign win_end_s = (cnt_r == CNT_W'(DIV_CNT - 1));

    // State, window counter and digit index registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_BLANK;
            cnt_r   <= {CNT_W{1'b0}};
            idx_r   <= {IDX_W{1'b0}};
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            idx_r   <= idx_s;
        end
    end

    // Next-state: BLANK for the first BLANK_CYC clocks, SHOW for the rest, wrap at window end
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r + CNT_W'(1);
        idx_s   = idx_r;
        if (win_end_s) begin
            cnt_s   = {CNT_W{1'b0}};
            state_s = ST_BLANK;
            if (idx_r == IDX_W'(N_DIGITS - 1)) begin
                idx_s = {IDX_W{1'b0}};
            end else begin
                idx_s = idx_r + IDX_W'(1);
            end
        end else begin
            case (state_r)
                ST_BLANK: begin
                    if (cnt_r == CNT_W'(BLANK_CYC - 1)) begin
                        state_s = ST_SHOW;
                    end else begin
                        state_s = ST_BLANK;
                    end
                end
                ST_SHOW:  state_s = ST_SHOW;
                default:  state_s = ST_BLANK;
            endcase
        end
    end

    assign show        = (state_r == ST_SHOW);
    assign blank_start = (state_r == ST_BLANK) && (cnt_r == {CNT_W{1'b0}});
    assign frame_end   = win_end_s && (idx_r == IDX_W'(N_DIGITS - 1));
    assign idx         = idx_r;

endmodule

// File: rtl/seg_scan_mux.sv
// Four-digit common-anode 7-segment scan driver with double-buffered patterns,
// anti-ghost blanking, leading-zero suppression on the tens digits and frame blink.
module seg_scan_mux
    import seg_pkg::*;
#(
    parameter int DIV_CNT      = 100000,
    parameter int BLANK_CYC    = 16,
    parameter int BLINK_FRAMES = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [6:0] val_one,
    input  logic [6:0] val_ten,
    input  logic [6:0] rem_one,
    input  logic [6:0] rem_ten,
    input  logic       lz_blank,
    input  logic       blink,
    output logic [6:0] seg_out,
    output logic [3:0] an_out,
    output logic       frame_done
);

    localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic                        show_s;
    logic                        blank_start_s;
    logic                        frame_end_s;
    logic [IDX_W-1:0]            idx_s;

    logic [N_DIGITS-1:0][6:0]    pending_r;
    logic [N_DIGITS-1:0][6:0]    shadow_r;
    logic                        pend_vld_r;
    logic [FRM_W-1:0]            frame_cnt_r;
    logic                        phase_on_r;

    logic [6:0]                  seg_s;
    logic [3:0]                  an_s;
    logic [6:0]                  digit_pat_s;

    seg_scan_timer #(
        .DIV_CNT   (DIV_CNT),
        .BLANK_CYC (BLANK_CYC)
    ) u_timer (
        .clk         (clk),
        .rst         (rst),
        .show        (show_s),
        .blank_start (blank_start_s),
        .frame_end   (frame_end_s),
        .idx         (idx_s)
    );

    // Pending/shadow buffers: shadow only changes at blank entry so a window never tears
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_r  <= {N_DIGITS{SEG_BLANK}};
            shadow_r   <= {N_DIGITS{SEG_BLANK}};
            pend_vld_r <= 1'b0;
        end else begin
            if (blank_start_s && pend_vld_r) begin
                shadow_r <= pending_r;
            end
            if (load) begin
                // A load coinciding with blank entry stays pending for the next window
                pending_r  <= {rem_ten, rem_one, val_ten, val_one};
                pend_vld_r <= 1'b1;
            end else if (blank_start_s && pend_vld_r) begin
                pend_vld_r <= 1'b0;
            end
        end
    end

    // Blink phase: toggles every BLINK_FRAMES frames; changes land at a window boundary
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt_r <= {FRM_W{1'b0}};
            phase_on_r  <= 1'b1;
        end else if (!blink) begin
            frame_cnt_r <= {FRM_W{1'b0}};
            phase_on_r  <= 1'b1;
        end else if (frame_end_s) begin
            if (frame_cnt_r == FRM_W'(BLINK_FRAMES - 1)) begin
                frame_cnt_r <= {FRM_W{1'b0}};
                phase_on_r  <= ~phase_on_r;
            end else begin
                frame_cnt_r <= frame_cnt_r + FRM_W'(1);
            end
        end
    end

    assign digit_pat_s = shadow_r[idx_s];

    // Output decode: blank unless showing a lit digit; suppress zero on odd (tens) digits
    always_comb begin
        seg_s = SEG_BLANK;
        an_s  = AN_OFF;
        if (show_s && !(blink && !phase_on_r)) begin
            an_s = anode_sel(idx_s);
            if (lz_blank && idx_s[0] && (digit_pat_s == SEG_ZERO)) begin
                seg_s = SEG_BLANK;
            end else begin
                seg_s = digit_pat_s;
            end
        end else begin
            seg_s = SEG_BLANK;
            an_s  = AN_OFF;
        end
    end

    // Registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_out    <= SEG_BLANK;
            an_out     <= AN_OFF;
            frame_done <= 1'b0;
        end else begin
            seg_out    <= seg_s;
            an_out     <= an_s;
            frame_done <= frame_end_s;
        end
    end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Directed bench for seg_scan_mux with an 8-clock window (2 blank + 6 show), 2-frame blink.
// pos counts clocks since reset release; after edge pos the outputs show window slot
// k=(pos-1)%8 of digit ((pos-1)/8)%4.
module tb_seg_scan_mux;
    import seg_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       load = 1'b0;
    logic [6:0] val_one = 7'b1111111;
    logic [6:0] val_ten = 7'b1111111;
    logic [6:0] rem_one = 7'b1111111;
    logic [6:0] rem_ten = 7'b1111111;
    logic       lz_blank = 1'b0;
    logic       blink = 1'b0;
    logic [6:0] seg_out;
    logic [3:0] an_out;
    logic       frame_done;

    int n_tests = 0;
    int n_fail  = 0;
    int pos     = 0;
    logic [6:0] exp_pat [4];

    seg_scan_mux #(
        .DIV_CNT      (8),
        .BLANK_CYC    (2),
        .BLINK_FRAMES (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .val_one    (val_one),
        .val_ten    (val_ten),
        .rem_one    (rem_one),
        .rem_ten    (rem_ten),
        .lz_blank   (lz_blank),
        .blink      (blink),
        .seg_out    (seg_out),
        .an_out     (an_out),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] exp_anode(input int d);
        logic [3:0] a;
        a    = 4'b1111;
        a[d] = 1'b0;
        return a;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        pos++;
    endtask

    // Advance at least one clock until the outputs show slot k of digit d
    task automatic goto(input int d, input int k);
        int guard;
        guard = 0;
        step();
        while (!((((pos - 1) % 8) == k) && ((((pos - 1) / 8) % 4) == d)) && guard < 64) begin
            step();
            guard++;
        end
        if (guard >= 64) begin
            n_tests++;
            n_fail++;
            $display("FAIL goto d=%0d k=%0d: position not reached within 64 clocks", d, k);
        end
    endtask

    task automatic do_load(input logic [6:0] p0, input logic [6:0] p1,
                           input logic [6:0] p2, input logic [6:0] p3);
        val_one = p0;
        val_ten = p1;
        rem_one = p2;
        rem_ten = p3;
        load    = 1'b1;
        step();
        load    = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_tests++;
            if (seg_out !== 7'b1111111 || an_out !== 4'b1111 || frame_done !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_hold cyc=%0d got seg=%b an=%b fd=%b want seg=1111111 an=1111 fd=0",
                         i, seg_out, an_out, frame_done);
            end
        end
        rst = 1'b0;
        pos = 0;
        for (int i = 0; i < 2; i++) begin
            step();
            n_tests++;
            if (seg_out !== 7'b1111111 || an_out !== 4'b1111 || frame_done !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_release cyc=%0d got seg=%b an=%b fd=%b want seg=1111111 an=1111 fd=0",
                         i, seg_out, an_out, frame_done);
            end
        end
    endtask

    task automatic test_scan_basic();
        lz_blank = 1'b0;
        do_load(7'b1111001, 7'b1000000, 7'b1000000, 7'b1000000);
        exp_pat[0] = 7'b1111001; exp_pat[1] = 7'b1000000;
        exp_pat[2] = 7'b1000000; exp_pat[3] = 7'b1000000;
        goto(0, 0);
        for (int i = 0; i < 32; i++) begin
            int k; int d;
            logic [3:0] ea; logic [6:0] es; logic ef;
            k  = (pos - 1) % 8;
            d  = ((pos - 1) / 8) % 4;
            ea = (k < 2) ? 4'b1111 : exp_anode(d);
            es = (k < 2) ? 7'b1111111 : exp_pat[d];
            ef = (d == 3) && (k == 7);
            n_tests++;
            if (an_out !== ea || seg_out !== es || frame_done !== ef) begin
                n_fail++;
                $display("FAIL scan_basic d=%0d k=%0d got an=%b seg=%b fd=%b want an=%b seg=%b fd=%b",
                         d, k, an_out, seg_out, frame_done, ea, es, ef);
            end
            step();
        end
    endtask

    task automatic test_lz_blank();
        lz_blank = 1'b1;
        exp_pat[0] = 7'b1111001; exp_pat[1] = 7'b1111111;
        exp_pat[2] = 7'b1000000; exp_pat[3] = 7'b1111111;
        for (int i = 0; i < 32; i++) begin
            int k; int d;
            logic [3:0] ea; logic [6:0] es;
            k  = (pos - 1) % 8;
            d  = ((pos - 1) / 8) % 4;
            ea = (k < 2) ? 4'b1111 : exp_anode(d);
            es = (k < 2) ? 7'b1111111 : exp_pat[d];
            n_tests++;
            if (an_out !== ea || seg_out !== es) begin
                n_fail++;
                $display("FAIL lz_zero d=%0d k=%0d got an=%b seg=%b want an=%b seg=%b",
                         d, k, an_out, seg_out, ea, es);
            end
            step();
        end
        do_load(7'b0011000, 7'b0011000, 7'b0011000, 7'b0011000);
        goto(0, 0);
        for (int i = 0; i < 32; i++) begin
            int k; int d;
            logic [3:0] ea; logic [6:0] es;
            k  = (pos - 1) % 8;
            d  = ((pos - 1) / 8) % 4;
            ea = (k < 2) ? 4'b1111 : exp_anode(d);
            es = (k < 2) ? 7'b1111111 : 7'b0011000;
            n_tests++;
            if (an_out !== ea || seg_out !== es) begin
                n_fail++;
                $display("FAIL lz_err d=%0d k=%0d got an=%b seg=%b want an=%b seg=%b",
                         d, k, an_out, seg_out, ea, es);
            end
            step();
        end
        lz_blank = 1'b0;
    endtask

    task automatic test_load_mid_window();
        // 10 / 4 : ones=0, tens=1, rem ones=4, rem tens=0
        exp_pat[0] = 7'b1000000; exp_pat[1] = 7'b1111001;
        exp_pat[2] = 7'b0011001; exp_pat[3] = 7'b1000000;
        goto(2, 3);
        do_load(7'b1000000, 7'b1111001, 7'b0011001, 7'b1000000);
        // rest of digit 2 keeps the old error pattern, digit 3 window shows the new one
        for (int i = 0; i < 12; i++) begin
            int k; int d;
            logic [3:0] ea; logic [6:0] es;
            k  = (pos - 1) % 8;
            d  = ((pos - 1) / 8) % 4;
            ea = (k < 2) ? 4'b1111 : exp_anode(d);
            es = (k < 2) ? 7'b1111111 : ((d == 2) ? 7'b0011000 : exp_pat[3]);
            n_tests++;
            if (an_out !== ea || seg_out !== es) begin
                n_fail++;
                $display("FAIL load_tear d=%0d k=%0d got an=%b seg=%b want an=%b seg=%b",
                         d, k, an_out, seg_out, ea, es);
            end
            step();
        end
        for (int i = 0; i < 24; i++) begin
            int k; int d;
            logic [3:0] ea; logic [6:0] es;
            k  = (pos - 1) % 8;
            d  = ((pos - 1) / 8) % 4;
            ea = (k < 2) ? 4'b1111 : exp_anode(d);
            es = (k < 2) ? 7'b1111111 : exp_pat[d];
            n_tests++;
            if (an_out !== ea || seg_out !== es) begin
                n_fail++;
                $display("FAIL load_new d=%0d k=%0d got an=%b seg=%b want an=%b seg=%b",
                         d, k, an_out, seg_out, ea, es);
            end
            step();
        end
        // two loads in one window: 3s then 5s, only 5s must appear
        goto(0, 2);
        do_load(7'b0110000, 7'b0110000, 7'b0110000, 7'b0110000);
        goto(0, 5);
        do_load(7'b0010010, 7'b0010010, 7'b0010010, 7'b0010010);
        goto(1, 2);
        for (int i = 0; i < 6; i++) begin
            n_tests++;
            if (an_out !== 4'b1101 || seg_out !== 7'b0010010) begin
                n_fail++;
                $display("FAIL load_last_wins cyc=%0d got an=%b seg=%b want an=1101 seg=0010010",
                         i, an_out, seg_out);
            end
            step();
        end
    endtask

    task automatic test_back_to_back();
        goto(1, 3);
        do_load(7'b1111000, 7'b1111000, 7'b1111000, 7'b1111000);
        goto(1, 7);
        // sampled exactly at blank entry of digit 2: the 7s transfer, the 8s stay pending
        do_load(7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000);
        for (int i = 0; i < 16; i++) begin
            int k; int d;
            logic [3:0] ea; logic [6:0] es;
            k  = (pos - 1) % 8;
            d  = ((pos - 1) / 8) % 4;
            ea = (k < 2) ? 4'b1111 : exp_anode(d);
            es = (k < 2) ? 7'b1111111 : ((d == 2) ? 7'b1111000 : 7'b0000000);
            n_tests++;
            if (an_out !== ea || seg_out !== es) begin
                n_fail++;
                $display("FAIL load_at_blank d=%0d k=%0d got an=%b seg=%b want an=%b seg=%b",
                         d, k, an_out, seg_out, ea, es);
            end
            step();
        end
    endtask

    task automatic test_blink();
        goto(3, 7);
        blink = 1'b1;
        for (int i = 0; i < 104; i++) begin
            int k; int d; int f;
            logic lit; logic [3:0] ea; logic [6:0] es; logic ef;
            step();
            f   = i / 32;
            lit = (f < 2);
            k   = (pos - 1) % 8;
            d   = ((pos - 1) / 8) % 4;
            ea  = (k < 2 || !lit) ? 4'b1111 : exp_anode(d);
            es  = (k < 2 || !lit) ? 7'b1111111 : 7'b0000000;
            ef  = (d == 3) && (k == 7);
            n_tests++;
            if (an_out !== ea || seg_out !== es || frame_done !== ef) begin
                n_fail++;
                $display("FAIL blink f=%0d d=%0d k=%0d got an=%b seg=%b fd=%b want an=%b seg=%b fd=%b",
                         f, d, k, an_out, seg_out, frame_done, ea, es, ef);
            end
        end
        blink = 1'b0;
        for (int i = 0; i < 8; i++) begin
            logic [3:0] ea; logic [6:0] es;
            step();
            ea = (i < 2) ? 4'b1111 : 4'b1101;
            es = (i < 2) ? 7'b1111111 : 7'b0000000;
            n_tests++;
            if (an_out !== ea || seg_out !== es) begin
                n_fail++;
                $display("FAIL blink_off k=%0d got an=%b seg=%b want an=%b seg=%b",
                         i, an_out, seg_out, ea, es);
            end
        end
    endtask

    task automatic test_reset_mid_scan();
        goto(1, 4);
        rst = 1'b1;
        step();
        n_tests++;
        if (seg_out !== 7'b1111111 || an_out !== 4'b1111 || frame_done !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset got seg=%b an=%b fd=%b want seg=1111111 an=1111 fd=0",
                     seg_out, an_out, frame_done);
        end
        rst = 1'b0;
        pos = 0;
        for (int i = 0; i < 32; i++) begin
            int k; int d;
            logic [3:0] ea; logic ef;
            step();
            k  = (pos - 1) % 8;
            d  = ((pos - 1) / 8) % 4;
            ea = (k < 2) ? 4'b1111 : exp_anode(d);
            ef = (pos == 32);
            n_tests++;
            if (an_out !== ea || seg_out !== 7'b1111111 || frame_done !== ef) begin
                n_fail++;
                $display("FAIL mid_reset_restart d=%0d k=%0d got an=%b seg=%b fd=%b want an=%b seg=1111111 fd=%b",
                         d, k, an_out, seg_out, frame_done, ea, ef);
            end
        end
    endtask

    initial begin
        test_reset();
        test_scan_basic();
        test_lz_blank();
        test_load_mid_window();
        test_back_to_back();
        test_blink();
        test_reset_mid_scan();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
